// File: rtl/disp_pkg.sv
// Shared constants and FSM state type for the display binary-to-BCD converter.
// BCD_DIGITS must satisfy 10**BCD_DIGITS > 2**DATA_W (covers DATA_W <= 32).
package disp_pkg;

  localparam int BCD_DIGITS = 10;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// One-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/disp_bcd_conv.sv
// Multi-cycle binary-to-display-digit converter (decimal via double-dabble, or hex pass-through).
// Optional macro BCD_LEADING_BLANK_EN replaces leading decimal zeros with the blank code.
module disp_bcd_conv
  import disp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_hex,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  out_valid,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // out_valid is a one-cycle pulse and has no back-pressure.

  localparam int ACC_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   digits_q, digits_d;
  logic                  ovf_q, ovf_d;

  logic [ACC_W-1:0]      acc_adj;
  logic [ACC_W-1:0]      acc_shift;
  logic [DATA_W-1:0]     sh_shift;
  logic [4*DIGITS-1:0]   dec_digits;
  logic                  dec_ovf;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (acc_q[4*g +: 4]),
      .q_o (acc_adj[4*g +: 4])
    );
  end

  assign acc_shift = {acc_adj[ACC_W-2:0], shift_q[DATA_W-1]};
  assign sh_shift  = {shift_q[DATA_W-2:0], 1'b0};

  // Result is formed from the final shifted accumulator so digits are valid during DONE.
  always_comb begin
`ifdef BCD_LEADING_BLANK_EN
    logic seen_nz;
`endif
    dec_ovf    = |acc_shift[ACC_W-1:4*DIGITS];
    dec_digits = acc_shift[4*DIGITS-1:0];
`ifdef BCD_LEADING_BLANK_EN
    seen_nz = dec_ovf;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (acc_shift[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (!seen_nz) dec_digits[4*i +: 4] = BLANK_CODE;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          acc_d   = '0;
          cnt_d   = '0;
          if (in_hex) begin
            state_d  = DONE;
            digits_d = in_data[4*DIGITS-1:0];
            ovf_d    = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d   = acc_shift;
        shift_d = sh_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d  = DONE;
          digits_d = dec_digits;
          ovf_d    = dec_ovf;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign digits    = digits_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: doc/disp_bcd_conv.md
# disp_bcd_conv

Sequential binary-to-display-digit converter that sits between the CPU's 32-bit display word and the 8-digit seven-segment scanner. In decimal mode it runs a shift-and-add-3 (double-dabble) conversion over multiple cycles. In hex mode it passes nibbles through. It holds the last result stable for the scanner and flags values that do not fit in the display.

## Interface

Parameters:
- DATA_W, 32, width of the binary input word.
- DIGITS, 8, number of 4-bit digits presented to the display.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  unsigned value to convert.
- in_hex  in  1  1 = hex pass-through, 0 = decimal conversion; sampled together with in_data.
- in_valid  in  1  request to convert.
- in_ready  out  1  block idle, so a request is accepted.
- digits  out  4*DIGITS  result; digit 0 is in bits [3:0] (least significant).
- out_valid  out  1  one-cycle pulse when digits has just been updated.
- overflow  out  1  last decimal result needed more than DIGITS digits; cleared by any hex result.

## Operation

- States: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE).
- IDLE, with in_valid=1:
  - capture in_data into the shift register and in_hex into the mode register.
  - clear the internal BCD accumulator (BCD_DIGITS = 10 digits).
  - zero the bit counter.
  - go to SHIFT if decimal, DONE if hex.
- SHIFT, each cycle:
  - every accumulator digit ≥ 5 gets +3.
  - then {accumulator, shift register} shifts left by 1.
  - the counter increments.
  - after DATA_W shifts, go to DONE.
- DONE, single cycle:
  - digits ← low DIGITS digits of the accumulator (decimal) or in_data[4*DIGITS-1:0] (hex).
  - overflow ← any upper accumulator digit nonzero (decimal) or 0 (hex).
  - out_valid = 1, then return to IDLE.
- in_valid while not IDLE is ignored. The requester must hold it until accepted.
- digits and overflow change only in DONE. Between results they hold their value.
- Width rule: BCD_DIGITS must satisfy 10^BCD_DIGITS > 2^DATA_W. The package constant covers DATA_W ≤ 32.

## Timing

- Reset (rst=0, asynchronous):
  - state = IDLE, digits = 0, overflow = 0, out_valid = 0, in_ready = 1.
  - Takes effect immediately, including mid-SHIFT. The partial result is discarded.
- Accept at rising edge T (in_valid & in_ready). in_ready is low from T until DONE completes.
- Decimal latency: SHIFT occupies edges T+1 … T+DATA_W. out_valid is high in the cycle after edge T+DATA_W, with digits valid in the same cycle. Next acceptance is possible at edge T+DATA_W+2.
- Hex latency: out_valid is high in the cycle after edge T. Next acceptance is possible at edge T+2.
- in_data / in_hex changes after acceptance have no effect on the conversion in flight.

## Configuration

- Macro BCD_LEADING_BLANK_EN.
- Defined: in decimal results, leading zero digits above digit 0 are replaced by 4'hF (the scanner's blank code). Digit 0 is never blanked. Hex results are unaffected.
- Undefined: leading zeros are shown as 0. No 4'hF ever appears in a decimal result.

## Structure

- Shared package disp_pkg holds:
  - BCD_DIGITS = 10.
  - the state enum (IDLE/SHIFT/DONE).
  - BLANK_CODE = 4'hF.
- One combinational sub-module, bcd_add3: one-digit "≥5 → +3" adjust, instantiated BCD_DIGITS times.
- Counter width: $clog2(DATA_W+1).

## Test plan

- Decimal 32'd12345678, in_hex=0 → out_valid 33 cycles after accept; digits = 32'h12345678, overflow = 0.
- Hex 32'hDEADBEEF, in_hex=1 → out_valid 1 cycle after accept; digits = 32'hDEADBEEF, overflow = 0.
- Decimal 32'hFFFFFFFF (4294967295) → digits = 32'h94967295, overflow = 1. A following hex request clears overflow.
- in_valid pulsed with 32'd7 while SHIFT is in progress → ignored. in_ready stays 0 and the first result is unchanged.
- Reset asserted at the 10th SHIFT cycle:
  - immediately digits = 0, out_valid = 0, in_ready = 1.
  - after release, a new request for 32'd99 yields 32'h00000099.
- Decimal 32'd42 and 32'd0:
  - with BCD_LEADING_BLANK_EN → 32'hFFFFFF42 and 32'hFFFFFFF0.
  - without → 32'h00000042 and 32'h00000000.
